// File: rtl/rv32e_pkg.sv
// rv32e_pkg: shared op codes, opcode/funct constants, error codes and FSM states for the IMEM loader
package rv32e_pkg;
  typedef enum logic [4:0] {
    ADDI, ANDI, ORI, XORI, SLTI, JALR,
    SLLI, SRLI, SRAI,
    ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT,
    LUI, AUIPC, JAL,
    BEQ, BNE, BLT, BGE
  } op_e;
  typedef enum logic [1:0] {S_LOAD, S_WRITE, S_DONE, S_ERR} state_e;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_STD     = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_OP     = 2'd1;
  localparam logic [1:0] ERR_RANGE  = 2'd2;
  localparam logic [1:0] ERR_OVF    = 2'd3;
  function automatic logic [2:0] funct3(input logic [4:0] op);
    case (op)
      SLLI, SLL, BNE:            return 3'b001;
      SLTI, SLT:                 return 3'b010;
      XORI, XOR, BLT:            return 3'b100;
      SRLI, SRAI, SRL, SRA, BGE: return 3'b101;
      ORI, OR:                   return 3'b110;
      ANDI, AND:                 return 3'b111;
      default:                   return 3'b000;
    endcase
  endfunction
endpackage

// File: rtl/rv32e_instr_encoder.sv
// rv32e_instr_encoder: combinational encode of op + fields into an RV32E word with legality check
//  in:  op, rd, rs1, rs2 (5b each), imm (32b signed)
//  out: word (32b), illegal, code (0 ok, 1 bad op, 2 register/immediate out of range)
module rv32e_instr_encoder
  import rv32e_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal,
  output logic [1:0]  code
);
  logic use_rd, use_rs1, use_rs2, imm_ok, bad_op, reg_ok;
  logic [2:0] f3;
  logic signed [31:0] simm;
  assign simm = imm;
  assign f3 = funct3(op);
  always_comb begin
    word = '0;
    use_rd = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    imm_ok = 1'b1;
    bad_op = 1'b0;
    case (op)
      ADDI, ANDI, ORI, XORI, SLTI, JALR: begin
        use_rd = 1'b1;
        use_rs1 = 1'b1;
        imm_ok = simm >= -2048 && simm <= 2047;
        word = {imm[11:0], rs1, f3, rd, op == JALR ? OPC_JALR : OPC_OP_IMM};
      end
      SLLI, SRLI, SRAI: begin
        use_rd = 1'b1;
        use_rs1 = 1'b1;
        imm_ok = imm[31:5] == '0;
        word = {op == SRAI ? F7_ALT : F7_STD, imm[4:0], rs1, f3, rd, OPC_OP_IMM};
      end
      ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT: begin
        use_rd = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        word = {op == SUB || op == SRA ? F7_ALT : F7_STD, rs2, rs1, f3, rd, OPC_OP};
      end
      LUI, AUIPC: begin
        use_rd = 1'b1;
        imm_ok = imm[31:20] == '0;
        word = {imm[19:0], rd, op == LUI ? OPC_LUI : OPC_AUIPC};
      end
      JAL: begin
        use_rd = 1'b1;
        imm_ok = !imm[0] && simm >= -1048576 && simm <= 1048574;
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      end
      BEQ, BNE, BLT, BGE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm_ok = !imm[0] && simm >= -4096 && simm <= 4094;
        word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
      end
      default: bad_op = 1'b1;
    endcase
  end
  // RV32E has 16 registers, so bit 4 of any used register field is illegal
  assign reg_ok = !(use_rd && rd[4]) && !(use_rs1 && rs1[4]) && !(use_rs2 && rs2[4]);
  assign illegal = bad_op || !reg_ok || !imm_ok;
  assign code = bad_op ? ERR_OP : illegal ? ERR_RANGE : ERR_NONE;
endmodule

// File: rtl/rv32e_imem_loader.sv
// rv32e_imem_loader: accepts decoded instructions, encodes and writes them to IMEM, holds the core in reset until done
//  in:  clk, rst_n (sync active-low), in_valid/in_op/in_rd/in_rs1/in_rs2/in_imm/in_last
//  out: in_ready, imem_we/imem_addr/imem_wdata, cpu_rst, done, err, err_code, count
module rv32e_imem_loader
  import rv32e_pkg::*;
#(
  parameter int IMEM_DEPTH = 64,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_op,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [31:0]   in_imm,
  input  logic          in_last,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_rst,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [AW:0]   count
);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(IMEM_DEPTH);
  state_e state_q, state_d;
  logic in_ready_q, in_ready_d, we_q, we_d, cpu_rst_q, cpu_rst_d;
  logic done_q, done_d, err_q, err_d, last_q, last_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, enc_word;
  logic [1:0] code_q, code_d, enc_code;
  logic [AW:0] count_q, count_d;
  logic enc_illegal;
  rv32e_instr_encoder u_enc (
    .op(in_op), .rd(in_rd), .rs1(in_rs1), .rs2(in_rs2), .imm(in_imm),
    .word(enc_word), .illegal(enc_illegal), .code(enc_code)
  );
  always_comb begin
    state_d = state_q;
    we_d = 1'b0;
    addr_d = addr_q;
    wdata_d = wdata_q;
    code_d = code_q;
    count_d = count_q;
    last_d = last_q;
    case (state_q)
      S_LOAD: if (in_valid && in_ready_q) begin
        if (count_q == CNT_FULL) begin
          state_d = S_ERR;
          code_d = ERR_OVF;
        end else if (enc_illegal) begin
          state_d = S_ERR;
          code_d = enc_code;
        end else begin
          state_d = S_WRITE;
          we_d = 1'b1;
          addr_d = count_q[AW-1:0];
          wdata_d = enc_word;
          last_d = in_last;
        end
      end
      S_WRITE: begin
        count_d = count_q + 1'b1;
        state_d = last_q ? S_DONE : S_LOAD;
      end
      default: ;
    endcase
    in_ready_d = state_d == S_LOAD;
    cpu_rst_d = state_d != S_DONE;
    done_d = state_d == S_DONE;
    err_d = state_d == S_ERR;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      in_ready_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      cpu_rst_q <= 1'b1;
      done_q <= 1'b0;
      err_q <= 1'b0;
      code_q <= ERR_NONE;
      count_q <= '0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      in_ready_q <= in_ready_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      cpu_rst_q <= cpu_rst_d;
      done_q <= done_d;
      err_q <= err_d;
      code_q <= code_d;
      count_q <= count_d;
      last_q <= last_d;
    end
  end
  assign in_ready = in_ready_q;
  assign imem_we = we_q;
  assign imem_addr = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst = cpu_rst_q;
  assign done = done_q;
  assign err = err_q;
  assign err_code = code_q;
  assign count = count_q;
endmodule

// File: tb/tb_rv32e_imem_loader.sv
// tb_rv32e_imem_loader: scoreboard bench with a field-level reference encoder for the IMEM loader
module tb_rv32e_imem_loader;
  localparam int DEPTH = 64;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [4:0] in_op = '0, in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic in_ready, imem_we, cpu_rst, done, err;
  logic [5:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [1:0] err_code;
  logic [6:0] count;
  int n_cmp = 0, n_bad = 0;
  bit [31:0] q_addr[$], q_data[$];
  int m_count, m_code;
  bit m_done, m_err;
  localparam int F3 [25] = '{0,7,6,4,2,0, 1,5,5, 0,0,7,6,4,1,5,5,2, 0,0,0, 0,1,4,5};
  localparam int OPC [25] = '{'h13,'h13,'h13,'h13,'h13,'h67, 'h13,'h13,'h13,
                              'h33,'h33,'h33,'h33,'h33,'h33,'h33,'h33,'h33,
                              'h37,'h17,'h6F, 'h63,'h63,'h63,'h63};

  rv32e_imem_loader dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .done(done), .err(err), .err_code(err_code), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  // Reference encoder: format chosen from the op number, fields placed by shift arithmetic
  function automatic void mdl(input int op, input int rd, input int rs1, input int rs2,
                              input bit [31:0] imm, output bit [31:0] w, output int code);
    int s;
    bit u_rd, u_rs1, u_rs2, ok;
    bit [31:0] f3, f7, opc;
    s = int'(imm);
    w = 0;
    code = 0;
    u_rd = 1; u_rs1 = 1; u_rs2 = 0; ok = 1;
    if (op > 24) begin
      code = 1;
      return;
    end
    f3 = F3[op];
    opc = OPC[op];
    f7 = (op == 8 || op == 10 || op == 16) ? 32'h20 : 32'h0;
    if (op <= 5) begin
      ok = s >= -2048 && s <= 2047;
      w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
    end else if (op <= 8) begin
      ok = s >= 0 && s <= 31;
      w = (f7 << 25) | (imm << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
    end else if (op <= 17) begin
      u_rs2 = 1;
      w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
    end else if (op <= 19) begin
      u_rs1 = 0;
      ok = imm <= 32'hFFFFF;
      w = (imm << 12) | (rd << 7) | opc;
    end else if (op == 20) begin
      u_rs1 = 0;
      ok = s % 2 == 0 && s >= -1048576 && s <= 1048574;
      w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21) | (((imm >> 11) & 1) << 20)
        | (((imm >> 12) & 255) << 12) | (rd << 7) | opc;
    end else begin
      u_rd = 0;
      u_rs2 = 1;
      ok = s % 2 == 0 && s >= -4096 && s <= 4094;
      w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15)
        | (f3 << 12) | (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7) | opc;
    end
    if ((u_rd && rd > 15) || (u_rs1 && rs1 > 15) || (u_rs2 && rs2 > 15) || !ok) code = 2;
  endfunction

  // Drive one beat, predict its outcome and wait until it is accepted; returns at the next negedge
  task automatic send(input int op, input int rd, input int rs1, input int rs2, input bit [31:0] imm,
                      input bit last, input bit use_exp, input bit [31:0] exp_w);
    bit [31:0] w;
    int code, n;
    mdl(op, rd, rs1, rs2, imm, w, code);
    if (use_exp) w = exp_w;
    if (m_count == DEPTH) code = 3;
    in_valid = 1'b1;
    in_op = 5'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
    in_imm = imm; in_last = last;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready stayed %0b, expected 1 within 50 cycles", in_ready);
      summary();
    end
    if (code == 0) begin
      q_addr.push_back(m_count);
      q_data.push_back(w);
      m_count++;
      m_done = last;
    end else begin
      m_err = 1;
      m_code = code;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic gen(input bit allow_bad, output int op, output int rd, output int rs1,
                     output int rs2, output bit [31:0] imm);
    op = $urandom_range(0, 24);
    rd = $urandom_range(0, 15); rs1 = $urandom_range(0, 15); rs2 = $urandom_range(0, 15);
    if (op <= 5) imm = $urandom_range(0, 4095) - 2048;
    else if (op <= 8) imm = $urandom_range(0, 31);
    else if (op <= 17) imm = $urandom;
    else if (op <= 19) imm = $urandom_range(0, 'hFFFFF);
    else if (op == 20) imm = ($urandom_range(0, 1048575) - 524288) * 2;
    else imm = ($urandom_range(0, 4095) - 2048) * 2;
    if (allow_bad && $urandom_range(0, 7) == 0)
      case ($urandom_range(0, 2))
        0: op = $urandom_range(25, 31);
        1: begin rd += 16; rs1 += 16; rs2 += 16; end
        default: imm = $urandom;
      endcase
  endtask

  task automatic do_reset(input bit check);
    in_valid = 1'b0;
    in_last = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (check) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_imem_we", imem_we, 0);
      chk("rst_imem_addr", imem_addr, 0);
      chk("rst_imem_wdata", imem_wdata, 0);
      chk("rst_cpu_rst", cpu_rst, 1);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_err_code", err_code, 0);
      chk("rst_count", count, 0);
    end
    rst_n = 1'b1;
    m_count = 0; m_code = 0; m_done = 0; m_err = 0;
    q_addr.delete();
    q_data.delete();
  endtask

  task automatic end_check(input string nm);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk({nm, "_done"}, done, m_done);
    chk({nm, "_err"}, err, m_err);
    chk({nm, "_err_code"}, err_code, m_code);
    chk({nm, "_count"}, count, m_count);
    chk({nm, "_cpu_rst"}, cpu_rst, !m_done);
    chk({nm, "_in_ready"}, in_ready, !(m_done || m_err));
    chk({nm, "_pending_writes"}, q_data.size(), 0);
  endtask

  task automatic run_random(input int n, input bit allow_bad, input bit use_last);
    int op, rd, rs1, rs2;
    bit [31:0] imm;
    for (int i = 0; i < n && !m_err && !m_done; i++) begin
      gen(allow_bad, op, rd, rs1, rs2, imm);
      send(op, rd, rs1, rs2, imm, use_last && i == n - 1, 0, 0);
      if ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
  endtask

  // Monitor: every write strobe must match the oldest predicted write
  always @(negedge clk) begin
    if (imem_we) begin
      chk("ready_during_write", in_ready, 0);
      if (q_data.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr %0d data %h, expected no write", imem_addr, imem_wdata);
      end else begin
        chk("write_addr", imem_addr, q_addr.pop_front());
        chk("write_data", imem_wdata, q_data.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time %0t, expected completion earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int op, rd, rs1, rs2;
    bit [31:0] imm;
    do_reset(1);
    send(0, 1, 0, 0, 5, 0, 1, 32'h00500093);
    send(9, 3, 1, 2, 0, 0, 1, 32'h002081B3);
    send(10, 3, 1, 2, 0, 1, 1, 32'h402081B3);
    in_valid = 1'b0;
    chk("prog1_strobe", imem_we, 1);
    chk("prog1_done_early", done, 0);
    @(negedge clk);
    chk("prog1_done", done, 1);
    chk("prog1_cpu_rst", cpu_rst, 0);
    end_check("prog1");

    do_reset(0);
    send(21, 0, 1, 2, 8, 0, 1, 32'h00208463);
    send(20, 1, 0, 0, 16, 0, 1, 32'h010000EF);
    send(18, 5, 0, 0, 32'h12345, 0, 1, 32'h123452B7);
    send(8, 4, 1, 0, 3, 1, 1, 32'h4030D213);
    end_check("prog2");

    do_reset(0);
    send(0, 16, 0, 0, 1, 1, 0, 0);
    chk("bad_reg_err", err, 1);
    chk("bad_reg_we", imem_we, 0);
    end_check("bad_reg");

    do_reset(0);
    send(21, 0, 1, 2, 7, 0, 0, 0);
    end_check("bad_branch_imm");

    do_reset(0);
    send(30, 1, 1, 1, 0, 0, 0, 0);
    end_check("bad_op");

    for (int k = 0; k < 6; k++) begin
      do_reset(0);
      run_random(20, k >= 3, 1);
      end_check("random");
    end

    do_reset(0);
    run_random(DEPTH + 1, 0, 0);
    end_check("overflow");

    do_reset(0);
    for (int i = 0; i < 2; i++) begin
      gen(0, op, rd, rs1, rs2, imm);
      send(op, rd, rs1, rs2, imm, 0, 0, 0);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midload_writes", q_data.size(), 0);
    do_reset(1);
    run_random(3, 0, 1);
    end_check("reload");
    summary();
  end
endmodule
